// File: rtl/wb_burst_ram.sv
// Wishbone B4 burst-capable RAM slave: classic cycles, CTI/BTE incrementing/wrapping bursts, byte lanes.
// Optional macro WB_BURST_RAM_WAIT_STATES_EN inserts WAIT_CYCLES before the first ack of each cycle.
module wb_burst_ram #(
  parameter int Dw          = 32,
  parameter int Aw          = 32,
  parameter int SELw        = Dw / 8,
  parameter int TAGw        = 3,
  parameter int CTIw        = 3,
  parameter int BTEw        = 2,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [Aw-1:0]   adr_i,
  input  logic [Dw-1:0]   dat_i,
  input  logic [SELw-1:0] sel_i,
  input  logic [TAGw-1:0] tag_i,
  input  logic            we_i,
  input  logic            stb_i,
  input  logic            cyc_i,
  input  logic [CTIw-1:0] cti_i,
  input  logic [BTEw-1:0] bte_i,
  output logic [Dw-1:0]   dat_o,
  output logic            ack_o,
  output logic            err_o,
  output logic            rty_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, CLASSIC, BURST, ERR} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [DEPTH_LOG2-1:0] wrap_mask, addr_inc;
  logic [Dw-1:0]         dat_q, dat_d;
  logic [Dw-1:0]         mem [DEPTH];
  logic                  req, out_of_range, is_incr, is_end, wait_done;
  logic                  unused_ok;

  assign unused_ok    = ^{tag_i, 32'(WAIT_CYCLES)};
  assign req          = cyc_i & stb_i;
  assign out_of_range = (adr_i >> DEPTH_LOG2) != '0;
  assign is_incr      = cti_i == CTIw'(3'b010);
  assign is_end       = cti_i == CTIw'(3'b111);

  // Wrap bursts increment only the masked low bits; linear uses a full mask so it rolls over at DEPTH.
  always_comb begin
    wrap_mask = '1;
    case (bte_i)
      BTEw'(2'b01): wrap_mask = DEPTH_LOG2'(3);
      BTEw'(2'b10): wrap_mask = DEPTH_LOG2'(7);
      BTEw'(2'b11): wrap_mask = DEPTH_LOG2'(15);
      default:      wrap_mask = '1;
    endcase
  end

  assign addr_inc = (addr_q & ~wrap_mask) | ((addr_q + DEPTH_LOG2'(1)) & wrap_mask);

`ifdef WB_BURST_RAM_WAIT_STATES_EN
  logic [7:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE)
      wait_d = (req && !out_of_range) ? 8'(WAIT_CYCLES) : '0;
    else if (!cyc_i)
      wait_d = '0;
    else if (wait_q != '0)
      wait_d = wait_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end

  assign wait_done = (wait_q == '0);
`else
  assign wait_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (out_of_range) begin
            state_d = ERR;
          end else begin
            addr_d  = adr_i[DEPTH_LOG2-1:0];
            state_d = is_incr ? BURST : CLASSIC;
          end
        end
      end
      CLASSIC: begin
        if (!cyc_i || ack_o) state_d = IDLE;
      end
      BURST: begin
        if (!cyc_i) begin
          state_d = IDLE;
        end else if (ack_o) begin
          addr_d = addr_inc;
          if (is_end) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered read of the address the next beat will use, so back-to-back beats need no wait.
  assign dat_d = mem[addr_d];

  always_comb begin
    ack_o = 1'b0;
    err_o = 1'b0;
    if (!reset) begin
      case (state_q)
        CLASSIC, BURST: ack_o = req & wait_done;
        ERR:            err_o = cyc_i;
        default:        ;
      endcase
    end
  end

  assign dat_o = dat_q;
  assign rty_o = 1'b0;

  always_ff @(posedge clk) begin
    if (we_i && ack_o) begin
      for (int unsigned i = 0; i < SELw; i++) begin
        if (sel_i[i]) mem[addr_q][8*i +: 8] <= dat_i[8*i +: 8];
      end
    end
  end

endmodule
